psg_bus_sched: RTL

Shares the single YM2149 register bus (BDIR/BC/DI/DO) between two requesters: the CPU port decoder and the register-stream player, which writes music frame data. Converts each request into a legal PSG bus-cycle sequence. Keeps a shadow of the CPU's latched address, so player writes that move the PSG address latch are invisible to CPU software. Sits between the bus decoders and the PSG instance, in the PSG clock domain (CLK).

---
 rtl/psg_bus_sched.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/psg_bus_sched.sv
`default_nettype none
// ============================================================================
// Module      : psg_bus_sched
// Description : Arbitrates the YM2149 register bus between the CPU port
//               decoder and the register-stream player. Turns each request
//               into a legal BDIR/BC cycle sequence and keeps a shadow of the
//               CPU-visible address latch so player writes stay invisible to
//               CPU software.
// Revision    : 1.0 - initial release
// ============================================================================
module psg_bus_sched (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cpu_req,
    input  logic [1:0] cpu_op,
    input  logic [7:0] cpu_din,
    output logic       cpu_ack,
    output logic [7:0] cpu_dout,
    input  logic       ply_req,
    input  logic [3:0] ply_addr,
    input  logic [7:0] ply_data,
    output logic       ply_ack,
    output logic       psg_bdir,
    output logic       psg_bc,
    output logic [7:0] psg_di,
    input  logic [7:0] psg_do,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    localparam logic [1:0] c_op_read = 2'b10;

    state_t     state_q, state_d;
    logic       gnt_cpu_q, gnt_cpu_d;     // current transaction belongs to the CPU
    logic       last_cpu_q, last_cpu_d;   // last grant went to the CPU
    logic [7:0] shadow_q, shadow_d;       // CPU's view of the address latch
    logic [7:0] cur_q, cur_d;             // value actually held in the PSG latch
    logic       cur_valid_q, cur_valid_d;
    logic [7:0] cpu_dout_q, cpu_dout_d;
    logic       cpu_ack_q, cpu_ack_d;
    logic       ply_ack_q, ply_ack_d;
    logic       psg_bdir_q, psg_bdir_d;
    logic       psg_bc_q, psg_bc_d;
    logic [7:0] psg_di_q, psg_di_d;

    logic       w_sel_cpu;
    logic       w_op_latch;
    logic       w_op_read;
    logic [7:0] w_tgt;
    logic [7:0] w_wdata;
    logic       w_hit;
    state_t     w_data_state;

    // Requester selection, target address and transition/bus-output decode
    always_comb begin
        state_d     = state_q;
        gnt_cpu_d   = gnt_cpu_q;
        last_cpu_d  = last_cpu_q;
        shadow_d    = shadow_q;
        cur_d       = cur_q;
        cur_valid_d = cur_valid_q;
        cpu_dout_d  = cpu_dout_q;
        psg_di_d    = psg_di_q;
        cpu_ack_d   = 1'b0;
        ply_ack_d   = 1'b0;
        psg_bdir_d  = 1'b0;
        psg_bc_d    = 1'b0;

        // In IDLE the grant is decided now; afterwards the stored grant holds.
        if (state_q == ST_IDLE) begin
            if (cpu_req && ply_req) begin
                w_sel_cpu = !last_cpu_q;
            end else begin
                w_sel_cpu = cpu_req;
            end
        end else begin
            w_sel_cpu = gnt_cpu_q;
        end

        // Op 11 decodes as an address latch, like op 00.
        w_op_latch   = w_sel_cpu && (cpu_op[1] == cpu_op[0]);
        w_op_read    = w_sel_cpu && (cpu_op == c_op_read);
        w_tgt        = w_sel_cpu ? (w_op_latch ? cpu_din : shadow_q)
                                 : {4'h0, ply_addr};
        w_wdata      = w_sel_cpu ? cpu_din : ply_data;
        w_hit        = cur_valid_q && (cur_q == w_tgt);
        w_data_state = w_op_read ? ST_READ : ST_WRITE;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req || ply_req) begin
                    gnt_cpu_d  = w_sel_cpu;
                    last_cpu_d = w_sel_cpu;
                    state_d    = (w_op_latch || !w_hit) ? ST_ADDR : w_data_state;
                end
            end
            ST_ADDR: begin
                cur_d       = w_tgt;
                cur_valid_d = 1'b1;
                if (w_op_latch) begin
                    shadow_d = cpu_din;
                    state_d  = ST_ACK;
                end else begin
                    state_d  = w_data_state;
                end
            end
            ST_WRITE: begin
                state_d = ST_ACK;
            end
            ST_READ: begin
                cpu_dout_d = psg_do;
                state_d    = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus pins are registered, so they are encoded from the state being entered.
        case (state_d)
            ST_ADDR: begin
                psg_bdir_d = 1'b1;
                psg_bc_d   = 1'b1;
                psg_di_d   = w_tgt;
            end
            ST_WRITE: begin
                psg_bdir_d = 1'b1;
                psg_di_d   = w_wdata;
            end
            ST_READ: begin
                psg_bc_d   = 1'b1;
            end
            ST_ACK: begin
                cpu_ack_d  = w_sel_cpu;
                ply_ack_d  = !w_sel_cpu;
            end
            default: begin
                psg_bdir_d = 1'b0;
            end
        endcase
    end

    // State, shadow/latch tracking and registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            gnt_cpu_q   <= 1'b0;
            last_cpu_q  <= 1'b0;
            shadow_q    <= 8'h00;
            cur_q       <= 8'h00;
            cur_valid_q <= 1'b0;
            cpu_dout_q  <= 8'hFF;
            cpu_ack_q   <= 1'b0;
            ply_ack_q   <= 1'b0;
            psg_bdir_q  <= 1'b0;
            psg_bc_q    <= 1'b0;
            psg_di_q    <= 8'h00;
        end else begin
            state_q     <= state_d;
            gnt_cpu_q   <= gnt_cpu_d;
            last_cpu_q  <= last_cpu_d;
            shadow_q    <= shadow_d;
            cur_q       <= cur_d;
            cur_valid_q <= cur_valid_d;
            cpu_dout_q  <= cpu_dout_d;
            cpu_ack_q   <= cpu_ack_d;
            ply_ack_q   <= ply_ack_d;
            psg_bdir_q  <= psg_bdir_d;
            psg_bc_q    <= psg_bc_d;
            psg_di_q    <= psg_di_d;
        end
    end

    assign cpu_ack  = cpu_ack_q;
    assign ply_ack  = ply_ack_q;
    assign cpu_dout = cpu_dout_q;
    assign psg_bdir = psg_bdir_q;
    assign psg_bc   = psg_bc_q;
    assign psg_di   = psg_di_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire
